// File: rtl/ks_chk_pkg.sv
// Shared types and helpers for the Kogge-Stone adder result checker.
package ks_chk_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DEF_W     = 16;
    localparam int DEF_CNT_W = 16;

    // Wide enough for any operand width up to 64; callers truncate to W+1.
    function automatic logic [64:0] golden_sum(input logic [63:0] x, input logic [63:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction
endpackage

// File: rtl/ks_chk_delay_line.sv
// LATENCY-stage shift register of {valid, x, y} aligning operands with the adder output.
module ks_chk_delay_line #(
    parameter int W       = 16,
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         out_valid,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y
);
    logic [LATENCY-1:0]        vld_pipe;
    logic [LATENCY-1:0][W-1:0] x_pipe;
    logic [LATENCY-1:0][W-1:0] y_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            x_pipe   <= '0;
            y_pipe   <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            x_pipe[0]   <= in_x;
            y_pipe[0]   <= in_y;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[LATENCY-1];
    assign out_x     = x_pipe[LATENCY-1];
    assign out_y     = y_pipe[LATENCY-1];
endmodule

// File: rtl/ks_result_checker.sv
// Checks a pipelined adder's sum against a golden sum over a run of vectors.
// Define KS_CHK_ERR_CAPTURE_EN to add first-mismatch capture outputs.
module ks_result_checker
    import ks_chk_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int LATENCY = 1,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] vec_count,
    input  logic             in_valid,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [W:0]       dut_s,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag
`ifdef KS_CHK_ERR_CAPTURE_EN
    ,
    output logic [W-1:0]     err_x,
    output logic [W-1:0]     err_y,
    output logic [W:0]       err_s,
    output logic [W:0]       err_exp
`endif
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] checked;
    logic             accept;
    logic             chk_v;
    logic [W-1:0]     chk_x;
    logic [W-1:0]     chk_y;
    logic [W:0]       exp_sum;
    logic             match;

    assign accept  = (state == RUN) && in_valid && (accepted < cnt);
    assign exp_sum = (W+1)'(golden_sum(64'(chk_x), 64'(chk_y)));
    assign match   = (dut_s == exp_sum);

    ks_chk_delay_line #(.W(W), .LATENCY(LATENCY)) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (chk_v),
        .out_x     (chk_x),
        .out_y     (chk_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            accepted <= '0;
            checked  <= '0;
            pass_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef KS_CHK_ERR_CAPTURE_EN
            err_x    <= '0;
            err_y    <= '0;
            err_s    <= '0;
            err_exp  <= '0;
`endif
        end else begin
            if (chk_v) begin
                if (checked != '1) checked <= checked + ONE;
                if (match) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + ONE;
                end else begin
                    if (err_cnt != '1) err_cnt <= err_cnt + ONE;
                    err_flag <= 1'b1;
`ifdef KS_CHK_ERR_CAPTURE_EN
                    if (!err_flag) begin
                        err_x   <= chk_x;
                        err_y   <= chk_y;
                        err_s   <= dut_s;
                        err_exp <= exp_sum;
                    end
`endif
                end
            end
            // Start clears are placed after the compare so they win on that edge.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= vec_count;
                        accepted <= '0;
                        checked  <= '0;
                        pass_cnt <= '0;
                        err_cnt  <= '0;
                        err_flag <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
`ifdef KS_CHK_ERR_CAPTURE_EN
                        err_x    <= '0;
                        err_y    <= '0;
                        err_s    <= '0;
                        err_exp  <= '0;
`endif
                    end
                end
                RUN: begin
                    if (accept) accepted <= accepted + ONE;
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (accept && (accepted + ONE == cnt)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (checked == cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ks_result_checker.sv
// Bench for ks_result_checker: two instances (LATENCY 1 and 3) against a queue-based run model.
// Honors KS_CHK_ERR_CAPTURE_EN when defined.
module tb_ks_result_checker;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_bad = 1'b0;
    logic [15:0] vec_count = '0, in_x = '0, in_y = '0;
    logic [16:0] sum_now, ds1, ds3;
    logic [2:0][16:0] pipe3;
    logic        busy1, done1, flag1, busy3, done3, flag3;
    logic [15:0] pass1, err1, pass3, err3;
`ifdef KS_CHK_ERR_CAPTURE_EN
    logic [15:0] ex1, ey1, ex3, ey3;
    logic [16:0] es1, ee1, es3, ee3;
`endif

    // Stand-in adders of latency 1 and 3; in_bad corrupts the sum for that operand pair.
    always_comb begin
        sum_now = {1'b0, in_x} + {1'b0, in_y};
        if (in_bad) sum_now = (sum_now == 17'h0) ? 17'h1 : 17'h0;
    end
    always @(posedge clk) begin
        ds1   <= sum_now;
        pipe3 <= {pipe3[1:0], sum_now};
    end
    assign ds3 = pipe3[2];

    ks_result_checker #(.W(16), .LATENCY(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count), .in_valid(in_valid),
        .in_x(in_x), .in_y(in_y), .dut_s(ds1), .busy(busy1), .done(done1),
        .pass_cnt(pass1), .err_cnt(err1), .err_flag(flag1)
`ifdef KS_CHK_ERR_CAPTURE_EN
        , .err_x(ex1), .err_y(ey1), .err_s(es1), .err_exp(ee1)
`endif
    );

    ks_result_checker #(.W(16), .LATENCY(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count), .in_valid(in_valid),
        .in_x(in_x), .in_y(in_y), .dut_s(ds3), .busy(busy3), .done(done3),
        .pass_cnt(pass3), .err_cnt(err3), .err_flag(flag3)
`ifdef KS_CHK_ERR_CAPTURE_EN
        , .err_x(ex3), .err_y(ey3), .err_s(es3), .err_exp(ee3)
`endif
    );

    int checks = 0, failures = 0, cyc = 0, tk = 0;
    bit armed = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int idx; int due; logic [15:0] x; logic [15:0] y; } ent_t;
    ent_t q[$];
    int   lat[2] = '{1, 3};
    int   m_st[2], m_cnt[2], m_acc[2], m_chk[2], m_pass[2], m_err[2];
    bit   m_flag[2];
    logic [15:0] m_ex[2], m_ey[2];
    logic [16:0] m_es[2], m_ee[2];

    task automatic mclear(input int i);
        m_acc[i] = 0; m_chk[i] = 0; m_pass[i] = 0; m_err[i] = 0; m_flag[i] = 0;
        m_ex[i] = '0; m_ey[i] = '0; m_es[i] = '0; m_ee[i] = '0;
    endtask

    // One clock edge for instance i, using the inputs that edge will sample.
    task automatic mstep(input int i, input logic [16:0] ds);
        int chk0 = m_chk[i];
        logic [16:0] e;
        bit acc;
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].idx == i && q[k].due == cyc) begin
                e = {1'b0, q[k].x} + {1'b0, q[k].y};
                m_chk[i]++;
                if (ds == e) m_pass[i]++;
                else begin
                    if (!m_flag[i]) begin
                        m_ex[i] = q[k].x; m_ey[i] = q[k].y; m_es[i] = ds; m_ee[i] = e;
                    end
                    m_err[i]++;
                    m_flag[i] = 1;
                end
                q.delete(k);
                break;
            end
        end
        acc = (m_st[i] == M_RUN) && in_valid && (m_acc[i] < m_cnt[i]);
        if (acc) q.push_back('{idx: i, due: cyc + lat[i], x: in_x, y: in_y});
        case (m_st[i])
            M_IDLE, M_DONE: if (start) begin
                m_st[i] = M_RUN; m_cnt[i] = int'(vec_count); mclear(i);
            end
            M_RUN: begin
                if (m_cnt[i] == 0) m_st[i] = M_DONE;
                else begin
                    if (acc) m_acc[i]++;
                    if (m_acc[i] == m_cnt[i]) m_st[i] = M_DRAIN;
                end
            end
            default: if (chk0 == m_cnt[i]) m_st[i] = M_DONE;
        endcase
    endtask

    task automatic compare_one(input int i, input logic b, input logic d, input logic [15:0] p,
                               input logic [15:0] er, input logic f);
        string n = (i == 0) ? "d1" : "d3";
        cmp({n, ".busy"}, int'(b), int'(m_st[i] == M_RUN || m_st[i] == M_DRAIN));
        cmp({n, ".done"}, int'(d), int'(m_st[i] == M_DONE));
        cmp({n, ".pass_cnt"}, int'(p), m_pass[i]);
        cmp({n, ".err_cnt"}, int'(er), m_err[i]);
        cmp({n, ".err_flag"}, int'(f), int'(m_flag[i]));
    endtask

    initial forever begin
        @(negedge clk);
        if (armed) begin
            compare_one(0, busy1, done1, pass1, err1, flag1);
            compare_one(1, busy3, done3, pass3, err3, flag3);
`ifdef KS_CHK_ERR_CAPTURE_EN
            cmp("d1.err_x", int'(ex1), int'(m_ex[0]));  cmp("d1.err_s", int'(es1), int'(m_es[0]));
            cmp("d1.err_y", int'(ey1), int'(m_ey[0]));  cmp("d1.err_exp", int'(ee1), int'(m_ee[0]));
            cmp("d3.err_x", int'(ex3), int'(m_ex[1]));  cmp("d3.err_s", int'(es3), int'(m_es[1]));
            cmp("d3.err_y", int'(ey3), int'(m_ey[1]));  cmp("d3.err_exp", int'(ee3), int'(m_ee[1]));
`endif
        end
        if (rst) begin
            q.delete();
            for (int i = 0; i < 2; i++) begin
                m_st[i] = M_IDLE; m_cnt[i] = 0; mclear(i);
            end
            armed = 1;
        end else begin
            mstep(0, ds1);
            mstep(1, ds3);
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
        tk++;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; vec_count = 16'(n);
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input bit bad);
        in_valid = 1'b1; in_x = x; in_y = y; in_bad = bad;
        tick;
        in_valid = 1'b0; in_bad = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick;
    endtask

    // Ticks until both instances show done; reports latency in ticks from t0.
    task automatic wait_done(input int t0, output int l1, output int l3);
        l1 = -1; l3 = -1;
        for (int n = 0; n < 400; n++) begin
            if (l1 < 0 && done1) l1 = tk - t0;
            if (l3 < 0 && done3) l3 = tk - t0;
            if (l1 >= 0 && l3 >= 0) return;
            tick;
        end
        cmp("wait_done_timeout", 0, 1);
    endtask

    initial begin
        int t0, l1, l3, n, sent;
        logic [15:0] rx, ry;
        idle(3);
        rst = 1'b0;
        cmp("reset.busy", int'(busy1), 0);
        cmp("reset.done", int'(done3), 0);
        cmp("reset.pass", int'(pass1), 0);
        cmp("reset.flag", int'(flag3), 0);

        // single vector: FFFF + 0001 = 10000
        t0 = tk; do_start(1); send(16'hFFFF, 16'h0001, 0); wait_done(t0, l1, l3);
        cmp("single.done_lat1", l1, 4);
        cmp("single.done_lat3", l3, 6);
        cmp("single.pass1", int'(pass1), 1);
        cmp("single.err1", int'(err1), 0);
        cmp("single.flag1", int'(flag1), 0);

        // three back-to-back
        t0 = tk; do_start(3);
        send(16'hFFFF, 16'h0001, 0); send(16'hAAAA, 16'h5555, 0); send(16'h1234, 16'h4321, 0);
        wait_done(t0, l1, l3);
        cmp("b2b.pass1", int'(pass1), 3);
        cmp("b2b.pass3", int'(pass3), 3);
        cmp("b2b.err3", int'(err3), 0);

        // fault on second vector
        t0 = tk; do_start(3);
        send(16'hFFFF, 16'h0001, 0); send(16'hAAAA, 16'h5555, 1); send(16'h1234, 16'h4321, 0);
        wait_done(t0, l1, l3);
        cmp("fault.pass1", int'(pass1), 2);
        cmp("fault.err1", int'(err1), 1);
        cmp("fault.flag3", int'(flag3), 1);
        cmp("fault.err3", int'(err3), 1);
`ifdef KS_CHK_ERR_CAPTURE_EN
        cmp("fault.err_x", int'(ex3), 'hAAAA);
        cmp("fault.err_y", int'(ey3), 'h5555);
        cmp("fault.err_s", int'(es1), 'h0);
        cmp("fault.err_exp", int'(ee1), 'h0FFFF);
`endif

        // gapped input, extra in_valid after count reached
        t0 = tk; do_start(2);
        send(16'h1111, 16'h2222, 0); idle(3);
        send(16'h3333, 16'h4444, 0); idle(3);
        send(16'h5555, 16'h6666, 1); idle(3);
        wait_done(t0, l1, l3);
        cmp("gap.pass3", int'(pass3), 2);
        cmp("gap.err3", int'(err3), 0);
        cmp("gap.pass1", int'(pass1), 2);

        // zero-length run
        t0 = tk; do_start(0); wait_done(t0, l1, l3);
        cmp("zero.lat1", l1, 2);
        cmp("zero.lat3", l3, 2);
        cmp("zero.pass", int'(pass3), 0);

        // start during RUN is ignored
        t0 = tk; do_start(3);
        start = 1'b1; vec_count = 16'd1;
        send(16'h0F0F, 16'hF0F0, 0);
        start = 1'b0;
        send(16'h8000, 16'h8000, 0); send(16'h0000, 16'h0000, 0);
        wait_done(t0, l1, l3);
        cmp("ign_start.pass1", int'(pass1), 3);
        cmp("ign_start.pass3", int'(pass3), 3);

        // start in DONE clears counters
        do_start(1);
        cmp("restart.pass1", int'(pass1), 0);
        cmp("restart.done1", int'(done1), 0);
        cmp("restart.busy1", int'(busy1), 1);
        t0 = tk; send(16'h0000, 16'h0000, 1); wait_done(t0, l1, l3);
        cmp("restart.err1", int'(err1), 1);

        // reset mid-run after one accepted vector
        do_start(3); send(16'h0101, 16'h0202, 0);
        rst = 1'b1; tick; rst = 1'b0;
        cmp("rst.busy1", int'(busy1), 0);
        cmp("rst.busy3", int'(busy3), 0);
        cmp("rst.err1", int'(err1), 0);
        idle(6);
        cmp("rst.stale_pass3", int'(pass3), 0);
        cmp("rst.stale_pass1", int'(pass1), 0);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 12);
            t0 = tk; do_start(n);
            sent = 0;
            while (sent < n + 2) begin
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 3))
                        0: rx = 16'hFFFF;
                        1: rx = 16'h0000;
                        default: rx = 16'($urandom);
                    endcase
                    ry = 16'($urandom);
                    send(rx, ry, $urandom_range(0, 4) == 0);
                    sent++;
                end else idle(1);
            end
            wait_done(t0, l1, l3);
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
